// File: rtl/mem_chk_pkg.sv
// rtl/mem_chk_pkg.sv - shared state and verdict encodings for the store-sequence checker
package mem_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISMATCH = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fail_code_t;

endpackage

// File: rtl/exp_table.sv
// rtl/exp_table.sv - expected (addr, data) register file with hit mask and match lookup
module exp_table #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IW    = 2,
  parameter int NW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr_hit,
  input  logic             set_hit,
  input  logic [IW-1:0]    set_idx,
  input  logic [NW-1:0]    n,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [DEPTH-1:0] match,
  output logic             unhit_any,
  output logic [IW-1:0]    unhit_idx
);
  import mem_chk_pkg::*;

  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] hit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      hit_q <= '0;
    end else begin
      if (we) begin
        addr_q[widx] <= waddr;
        data_q[widx] <= wdata;
      end
      if (clr_hit)
        hit_q <= '0;
      else if (set_hit)
        hit_q[set_idx] <= 1'b1;
    end
  end

  // Only entries below the active count take part in matching.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      match[i] = (NW'(i) < n) && (addr_q[i] == adr) && (data_q[i] == writedata);
  end

  always_comb begin
    unhit_any = 1'b0;
    unhit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i] && !hit_q[i]) begin
        unhit_any = 1'b1;
        unhit_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - watches core data-memory stores against a programmed table, sticky verdict
module mem_write_checker #(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH       = 4,
  parameter bit          ORDERED     = 1'b1,
  parameter bit          IGNORE_EN   = 1'b1,
  parameter logic [31:0] IGNORE_ADDR = 32'd80,
  parameter int          TIMEOUT     = 100,
  parameter int          IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int          NW          = $clog2(DEPTH + 1),
  parameter int          CW          = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             exp_we,
  input  logic [IW-1:0]    exp_idx,
  input  logic [WIDTH-1:0] exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [NW-1:0]    exp_n,
  input  logic             start,
  input  logic             clear,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [IW-1:0]    fail_idx,
  output logic [NW-1:0]    match_count,
  output logic [CW-1:0]    cycle_count
);
  import mem_chk_pkg::*;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [NW-1:0]   n_q;
  logic [NW-1:0]   n_clamped;
  logic [DEPTH-1:0] match;
  logic            unhit_any;
  logic [IW-1:0]   unhit_idx;
  logic            is_store;
  logic            store_ok;
  logic [NW-1:0]   mc_next;
  logic [CW-1:0]   cyc_next;

  always_comb begin
    n_clamped = exp_n;
    if (exp_n == '0)
      n_clamped = NW'(1);
    else if (exp_n > NW'(DEPTH))
      n_clamped = NW'(DEPTH);
  end

  assign is_store = (state == ST_RUN) && memwrite &&
                    !(IGNORE_EN && (adr == WIDTH'(IGNORE_ADDR)));
  assign store_ok = ORDERED ? match[ptr] : unhit_any;
  assign mc_next  = match_count + NW'(1);
  assign cyc_next = (cycle_count == CW'(TIMEOUT)) ? cycle_count : cycle_count + CW'(1);

  exp_table #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .IW   (IW),
    .NW   (NW)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (exp_we && (state == ST_IDLE)),
    .widx     (exp_idx),
    .waddr    (exp_addr),
    .wdata    (exp_data),
    .clr_hit  (start && (state == ST_IDLE)),
    .set_hit  (is_store && store_ok && !ORDERED),
    .set_idx  (unhit_idx),
    .n        (n_q),
    .adr      (adr),
    .writedata(writedata),
    .match    (match),
    .unhit_any(unhit_any),
    .unhit_idx(unhit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      n_q         <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FC_NONE;
      fail_idx    <= '0;
      match_count <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q         <= n_clamped;
            ptr         <= '0;
            match_count <= '0;
            cycle_count <= '0;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          cycle_count <= cyc_next;
          // A final match on the timeout cycle still counts as a pass.
          if (is_store && store_ok) begin
            match_count <= mc_next;
            ptr         <= ptr + IW'(1);
            if (mc_next == n_q) begin
              state <= ST_PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else if (cyc_next == CW'(TIMEOUT)) begin
              state     <= ST_FAIL;
              done      <= 1'b1;
              fail_code <= FC_TIMEOUT;
            end
          end else if (is_store) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            fail_code <= FC_MISMATCH;
            fail_idx  <= ORDERED ? ptr : '0;
          end else if (cyc_next == CW'(TIMEOUT)) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            fail_code <= FC_TIMEOUT;
          end
        end
        default: begin
          if (clear) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_idx    <= '0;
            match_count <= '0;
            cycle_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - directed bench driving an ordered and an unordered checker in parallel
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] writedata = '0;
  logic        exp_we = 1'b0;
  logic [1:0]  exp_idx = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [2:0]  exp_n = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;

  logic        o_done, u_done;
  logic        o_pass, u_pass;
  logic [1:0]  o_fc, u_fc;
  logic [1:0]  o_fidx, u_fidx;
  logic [2:0]  o_mc, u_mc;
  logic [6:0]  o_cc, u_cc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.ORDERED(1'b1)) dut_o (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_n(exp_n), .start(start), .clear(clear),
    .done(o_done), .pass(o_pass), .fail_code(o_fc), .fail_idx(o_fidx),
    .match_count(o_mc), .cycle_count(o_cc)
  );

  mem_write_checker #(.ORDERED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_n(exp_n), .start(start), .clear(clear),
    .done(u_done), .pass(u_pass), .fail_code(u_fc), .fail_idx(u_fidx),
    .match_count(u_mc), .cycle_count(u_cc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] n);
    exp_n = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; adr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_fc", {30'd0, o_fc}, 0);
    chk("rst_mc", {29'd0, o_mc}, 0);
    reset = 1'b1;
    tick();

    // Ignored scratch store, then the single expected store.
    load(2'd0, 32'd84, 32'd7);
    go(3'd1);
    store(32'd80, 32'd3);
    chk("ign_done", {31'd0, o_done}, 0);
    chk("ign_mc", {29'd0, o_mc}, 0);
    store(32'd84, 32'd7);
    chk("s1_done", {31'd0, o_done}, 1);
    chk("s1_pass", {31'd0, o_pass}, 1);
    chk("s1_fc", {30'd0, o_fc}, 0);
    chk("s1_mc", {29'd0, o_mc}, 1);
    chk("s1_u_pass", {31'd0, u_pass}, 1);
    do_clear();

    // Out-of-order stores: ordered fails at entry 0, unordered passes.
    load(2'd1, 32'd88, 32'd9);
    go(3'd2);
    store(32'd88, 32'd9);
    chk("ord_done", {31'd0, o_done}, 1);
    chk("ord_fc", {30'd0, o_fc}, 1);
    chk("ord_fidx", {30'd0, o_fidx}, 0);
    chk("ord_mc", {29'd0, o_mc}, 0);
    chk("un_mid_done", {31'd0, u_done}, 0);
    chk("un_mid_mc", {29'd0, u_mc}, 1);
    store(32'd84, 32'd7);
    chk("un_pass", {31'd0, u_pass}, 1);
    chk("un_mc", {29'd0, u_mc}, 2);
    chk("ord_sticky_fc", {30'd0, o_fc}, 1);
    do_clear();

    // Duplicate of an already-hit entry is a mismatch when unordered.
    go(3'd2);
    store(32'd88, 32'd9);
    store(32'd88, 32'd9);
    chk("dup_done", {31'd0, u_done}, 1);
    chk("dup_fc", {30'd0, u_fc}, 1);
    chk("dup_fidx", {30'd0, u_fidx}, 0);
    chk("dup_mc", {29'd0, u_mc}, 1);
    do_clear();

    // No stores: timeout verdict after exactly 100 RUN cycles.
    go(3'd1);
    for (int i = 0; i < 99; i++) tick();
    chk("to_pre_done", {31'd0, o_done}, 0);
    chk("to_pre_cc", {25'd0, o_cc}, 99);
    tick();
    chk("to_done", {31'd0, o_done}, 1);
    chk("to_fc", {30'd0, o_fc}, 2);
    chk("to_cc", {25'd0, o_cc}, 100);
    do_clear();

    // Matching store on the last allowed cycle wins over timeout.
    go(3'd1);
    for (int i = 0; i < 99; i++) tick();
    store(32'd84, 32'd7);
    chk("tow_pass", {31'd0, o_pass}, 1);
    chk("tow_fc", {30'd0, o_fc}, 0);
    chk("tow_cc", {25'd0, o_cc}, 100);
    do_clear();

    // Data mismatch, then clear and rerun against the retained table.
    go(3'd1);
    store(32'd84, 32'd8);
    chk("mm_fc", {30'd0, o_fc}, 1);
    chk("mm_u_fc", {30'd0, u_fc}, 1);
    do_clear();
    chk("clr_done", {31'd0, o_done}, 0);
    chk("clr_fc", {30'd0, o_fc}, 0);
    chk("clr_cc", {25'd0, o_cc}, 0);
    go(3'd0);
    store(32'd84, 32'd7);
    chk("rerun_pass", {31'd0, o_pass}, 1);
    chk("rerun_mc", {29'd0, o_mc}, 1);
    do_clear();

    // Asynchronous reset mid-RUN after one match; table is wiped.
    go(3'd2);
    store(32'd84, 32'd7);
    chk("pre_rst_mc", {29'd0, o_mc}, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mc", {29'd0, o_mc}, 0);
    chk("arst_cc", {25'd0, o_cc}, 0);
    chk("arst_u_mc", {29'd0, u_mc}, 0);
    #2 reset = 1'b1;
    tick();
    chk("post_rst_done", {31'd0, o_done}, 0);
    go(3'd1);
    store(32'd0, 32'd0);
    chk("zero_tbl_pass", {31'd0, o_pass}, 1);
    chk("zero_tbl_u_pass", {31'd0, u_pass}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised store-sequence checker for MIPS processor benches and on-board self-test. It watches the core's data-memory write port (`memwrite`, `adr`, `writedata`) against a programmable table of up to DEPTH expected (address, data) stores. It ignores stores to one scratch address and produces a sticky pass/fail/timeout verdict with diagnostic index and counters. It sits beside `mips_multi_top`, replacing hard-coded single-store checks and fixed cycle limits.

## Interface
- WIDTH, 32, address and data width
- DEPTH, 4, max expected stores in table (≥1)
- ORDERED, 1, 1 = stores must match table in index order; 0 = any order, each entry matched once
- IGNORE_EN, 1, enable ignore-address filtering
- IGNORE_ADDR, 80, store address that is never checked
- TIMEOUT, 100, RUN cycles allowed before timeout verdict (≥1)

- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low (0 = in reset)
- memwrite  in  1  core store strobe
- adr  in  WIDTH  core store address
- writedata  in  WIDTH  core store data
- exp_we  in  1  write table entry (IDLE only)
- exp_idx  in  $clog2(DEPTH)  table entry index
- exp_addr, exp_data  in  WIDTH  entry contents
- exp_n  in  $clog2(DEPTH+1)  number of stores to expect, sampled on start
- start  in  1  IDLE→RUN
- clear  in  1  PASS/FAIL→IDLE
- done  out  1  verdict valid
- pass  out  1  all expected stores seen
- fail_code  out  2  00 NONE, 01 MISMATCH, 10 TIMEOUT
- fail_idx  out  $clog2(DEPTH)  ORDERED: entry pending at mismatch; else 0
- match_count  out  $clog2(DEPTH+1)  entries matched so far
- cycle_count  out  $clog2(TIMEOUT+1)  RUN cycles elapsed, saturating at TIMEOUT

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: exp_we writes entry exp_idx. start latches exp_n, clears counters, ptr and hit mask, and enters RUN. exp_n=0 or exp_n>DEPTH is clamped to 1 or DEPTH.
- RUN: each cycle cycle_count++.
- A store is a cycle with memwrite=1. Stores with IGNORE_EN and adr==IGNORE_ADDR have no effect.
- ORDERED=1: a store equal to entry[ptr] gives ptr++ and match_count++. Otherwise go to FAIL with MISMATCH and fail_idx=ptr.
- ORDERED=0: a store equal to any unhit entry below n sets the lowest such hit bit and increments match_count. A store matching no unhit entry goes to FAIL with MISMATCH. A duplicate of an already-hit entry counts as a mismatch.
- When match_count reaches n, go to PASS.
- When cycle_count reaches TIMEOUT with no pass, go to FAIL with TIMEOUT.
- Final match and timeout in the same cycle: PASS wins.
- PASS/FAIL are sticky. Stores are ignored. clear returns to IDLE with the table retained and outputs zeroed.
- start outside IDLE and exp_we outside IDLE are ignored.
- Reset: state IDLE, table and hit mask cleared, all outputs 0.

## Timing
- Inputs are sampled at posedge. done/pass/fail_code are registered and asserted in the cycle after the deciding posedge.
- The first RUN cycle is the cycle after start. Stores presented with start are not checked.
- An exp_we entry is usable by a start one cycle later.
- Reset mid-RUN: outputs drop to 0 asynchronously. Nothing resumes after release.
- Zero-latency match: back-to-back stores on consecutive cycles are each checked.

## Structure
- Package `mem_chk_pkg`: state enum (IDLE, RUN, PASS, FAIL) and fail_code enum (NONE, MISMATCH, TIMEOUT).
- Sub-module `exp_table`: DEPTH-entry addr/data register file plus hit mask. Provides a combinational match vector against (adr, writedata) and lowest-unhit-match select.
- Top holds the FSM, ptr, counters and verdict registers.

## Test plan
- Load entry0=(84,7), n=1, start. Stores (80,3) then (84,7). Result: pass=1, fail_code=00, match_count=1, done the cycle after the second store.
- ORDERED=1, entries (84,7),(88,9), n=2. Store (88,9) first. Result: fail_code=01, fail_idx=0, match_count=0.
- ORDERED=0, same table. Stores (88,9) then (84,7) give pass=1. A repeated (88,9) before (84,7) gives fail_code=01.
- n=1, no stores for 100 cycles: done with fail_code=10 and cycle_count=100. Variant with the matching store on cycle 100: pass=1.
- Store (84,8) against entry (84,7): MISMATCH. Then clear then start, followed by (84,7): pass=1, with the table retained.
- Assert reset mid-RUN after one match: all outputs 0 immediately. After release, state is IDLE and start with an unloaded table expects (0,0).
